// File: rtl/fa_using_ha.sv
// Registered WIDTH-bit ripple-carry adder built from half-adder cells.
// Define FA_OVERFLOW_EN to add a registered two's-complement overflow output.

module ha (
   input  logic x,
   input  logic y,
   output logic s,
   output logic co
);
   assign s  = x ^ y;
   assign co = x & y;
endmodule

module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   logic p, g1, g2;

   ha u_ha1 (.x(a), .y(b),   .s(p), .co(g1));
   ha u_ha2 (.x(p), .y(cin), .s(s), .co(g2));

   assign cout = g1 | g2;
endmodule

module fa_using_ha #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             carry
`ifdef FA_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);
   // cy[i] is the carry into bit i; cy[WIDTH] is the carry-out of the MSB cell.
   logic [WIDTH:0]   cy;
   logic [WIDTH-1:0] sum_d;
   logic             carry_d;

   assign cy[0] = c;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fa_cell u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (cy[i]),
         .s    (sum_d[i]),
         .cout (cy[i+1])
      );
   end

   assign carry_d = cy[WIDTH];

   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         carry_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
         end
      end
   end

   assign out_valid = valid_q;
   assign sum       = sum_q;
   assign carry     = carry_q;

`ifdef FA_OVERFLOW_EN
   // Signed overflow: carry into the sign bit differs from carry out of it.
   logic ovf_d, ovf_q;
   assign ovf_d = cy[WIDTH-1] ^ cy[WIDTH];

   always_ff @(posedge clk) begin
      if (rst)           ovf_q <= 1'b0;
      else if (in_valid) ovf_q <= ovf_d;
   end

   assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_fa_using_ha.sv
// Scoreboard bench: WIDTH=1, 8 and 16 instances share clock and reset.

module tb_fa_using_ha;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   typedef struct {
      logic [16:0] res;
      logic        ov;
   } exp_t;

   exp_t q1[$], q8[$], q16[$];
   int checks = 0;
   int errors = 0;

   logic        v1, a1, b1, c1, o1v, s1, co1;
   logic        v8, c8, o8v, co8;
   logic [7:0]  a8, b8, s8;
   logic        v16, c16, o16v, co16;
   logic [15:0] a16, b16, s16;
`ifdef FA_OVERFLOW_EN
   logic        of1, of8, of16;
`endif

   fa_using_ha #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c(c1),
      .out_valid(o1v), .sum(s1), .carry(co1)
`ifdef FA_OVERFLOW_EN
      , .overflow(of1)
`endif
   );
   fa_using_ha #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c(c8),
      .out_valid(o8v), .sum(s8), .carry(co8)
`ifdef FA_OVERFLOW_EN
      , .overflow(of8)
`endif
   );
   fa_using_ha #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .c(c16),
      .out_valid(o16v), .sum(s16), .carry(co16)
`ifdef FA_OVERFLOW_EN
      , .overflow(of16)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic orphan(input string name);
      checks++;
      errors++;
      $display("FAIL %s: out_valid with empty scoreboard", name);
   endtask

   // Monitors: pop expected result whenever a DUT presents out_valid.
   always @(negedge clk) begin
      exp_t e;
      if (o1v === 1'b1) begin
         if (q1.size() == 0) orphan("w1_orphan");
         else begin
            e = q1.pop_front();
            chk("w1_res", {30'd0, co1, s1}, {15'd0, e.res});
`ifdef FA_OVERFLOW_EN
            chk("w1_ovf", {31'd0, of1}, {31'd0, e.ov});
`endif
         end
      end
      if (o8v === 1'b1) begin
         if (q8.size() == 0) orphan("w8_orphan");
         else begin
            e = q8.pop_front();
            chk("w8_res", {23'd0, co8, s8}, {15'd0, e.res});
`ifdef FA_OVERFLOW_EN
            chk("w8_ovf", {31'd0, of8}, {31'd0, e.ov});
`endif
         end
      end
      if (o16v === 1'b1) begin
         if (q16.size() == 0) orphan("w16_orphan");
         else begin
            e = q16.pop_front();
            chk("w16_res", {15'd0, co16, s16}, {15'd0, e.res});
`ifdef FA_OVERFLOW_EN
            chk("w16_ovf", {31'd0, of16}, {31'd0, e.ov});
`endif
         end
      end
   end

   // WIDTH=1 truth table indexed by {a,b,c}: {carry,sum} and signed overflow.
   logic [1:0] w1_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
   logic       w1_ov  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   // WIDTH=8 directed vectors: a, b, c, expected {carry,sum}, overflow.
   logic [7:0] v8_a   [6] = '{8'hFF, 8'h5A, 8'h80, 8'hFF, 8'h00, 8'h7F};
   logic [7:0] v8_b   [6] = '{8'h00, 8'hA5, 8'h80, 8'hFF, 8'h00, 8'h00};
   logic       v8_c   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [8:0] v8_exp [6] = '{9'h100, 9'h0FF, 9'h100, 9'h1FF, 9'h000, 9'h080};
   logic       v8_ov  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      logic [2:0]  idx;
      logic [16:0] r;
      rst = 1'b1;
      v1 = 0; a1 = 0; b1 = 0; c1 = 0;
      v8 = 0; a8 = 0; b8 = 0; c8 = 0;
      v16 = 0; a16 = 0; b16 = 0; c16 = 0;
      tick();
      tick();
      chk("rst_w1",  {29'd0, o1v, co1, s1}, 32'd0);
      chk("rst_w8",  {22'd0, o8v, co8, s8}, 32'd0);
      chk("rst_w16", {14'd0, o16v, co16, s16}, 32'd0);
`ifdef FA_OVERFLOW_EN
      chk("rst_ovf", {29'd0, of1, of8, of16}, 32'd0);
`endif
      rst = 1'b0;

      // WIDTH=1 exhaustive, back to back
      for (int i = 0; i < 8; i++) begin
         idx = 3'(i);
         v1 = 1; a1 = idx[2]; b1 = idx[1]; c1 = idx[0];
         e.res = {15'd0, w1_exp[i]};
         e.ov  = w1_ov[i];
         q1.push_back(e);
         tick();
      end

      // Hold: result stays while in_valid is low
      v1 = 1; a1 = 1; b1 = 1; c1 = 0;
      e.res = 17'h2; e.ov = 1'b1;
      q1.push_back(e);
      tick();
      v1 = 0; a1 = 0; b1 = 0; c1 = 1;
      tick();
      chk("hold_valid", {31'd0, o1v}, 32'd0);
      chk("hold_res", {30'd0, co1, s1}, 32'd2);
      tick();
      chk("hold_res2", {30'd0, co1, s1}, 32'd2);

      // Reset wins over a same-cycle in_valid
      rst = 1; v1 = 1; a1 = 1; b1 = 1; c1 = 1;
      tick();
      rst = 0; v1 = 0;
      chk("rstpri_valid", {31'd0, o1v}, 32'd0);
      chk("rstpri_res", {30'd0, co1, s1}, 32'd0);
      tick();
      chk("rstpri_after", {31'd0, o1v}, 32'd0);

      // WIDTH=8 directed, back to back
      for (int i = 0; i < 6; i++) begin
         v8 = 1; a8 = v8_a[i]; b8 = v8_b[i]; c8 = v8_c[i];
         e.res = {8'd0, v8_exp[i]};
         e.ov  = v8_ov[i];
         q8.push_back(e);
         tick();
      end
      v8 = 0; a8 = 8'h12; b8 = 8'h34; c8 = 1;
      tick();
      chk("w8_hold_valid", {31'd0, o8v}, 32'd0);
      chk("w8_hold_res", {23'd0, co8, s8}, 32'h080);

      // WIDTH=16 random regression, back to back
      for (int i = 0; i < 1000; i++) begin
         v16 = 1;
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         c16 = 1'($urandom);
         r = {1'b0, a16} + {1'b0, b16} + {16'd0, c16};
         e.res = r;
         e.ov  = (a16[15] == b16[15]) && (r[15] != a16[15]);
         q16.push_back(e);
         tick();
      end
      v16 = 0;
      tick();
      tick();
      chk("sb_drained", q1.size() + q8.size() + q16.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fa_using_ha.md
Name: fa_using_ha

Overview:
Registered full adder built structurally from half-adder cells. Each bit cell is two half adders plus an OR on their carries. Cells chain into a ripple-carry adder of WIDTH bits. With WIDTH=1 the block is the classic 1-bit full adder (a, b, carry-in c → sum, carry). It is used as an arithmetic leaf cell in datapaths that want a registered adder result.

Parameters:
WIDTH, 1, operand width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  qualifies a, b, c this cycle
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
c  input  1  carry-in into bit 0
out_valid  output  1  sum/carry hold a new result
sum  output  WIDTH  registered sum bits
carry  output  1  registered carry-out of the MSB cell

Behaviour:
- Half adder cell (ha): s = x XOR y; co = x AND y. Structural only; no behavioural "+" in the datapath.
- Full adder cell, bit i:
  - ha1(a[i], b[i]) → p, g1.
  - ha2(p, cin_i) → sum_i, g2.
  - cout_i = g1 OR g2.
  - cin_0 = c; cin_(i+1) = cout_i.
- Combinational result (sum_comb, carry_comb) equals {carry, sum} = a + b + c, computed in WIDTH+1 bits with no truncation.
- Register stage on rising clk:
  - rst=1: sum←0, carry←0, out_valid←0. Reset has priority over in_valid.
  - rst=0, in_valid=1: sum←sum_comb, carry←carry_comb, out_valid←1.
  - rst=0, in_valid=0: sum and carry hold their previous values; out_valid←0.
- Latency: exactly 1 clock from the in_valid sample to out_valid. Throughput: one result per cycle; back-to-back valids are allowed.
- Boundaries:
  - All-ones operands with c=1 give sum=all-ones and carry=1. For WIDTH=1: 1+1+1 → sum=1, carry=1.
  - All zeros with c=0 gives sum=0, carry=0.
  - Full-length carry propagation (a=all-ones, b=0, c=1) must settle within one cycle. Result: sum=0, carry=1.
- Reset mid-stream: an in_valid asserted in the same cycle as rst is dropped. out_valid is 0 in the following cycle.
- No X propagation: with reset applied, outputs are defined from the first clock onward.

Optional Feature:
FA_OVERFLOW_EN:
- Defined: adds output port "overflow" (1 bit, registered alongside sum).
  - overflow = cin_(WIDTH-1) XOR cout_(WIDTH-1), i.e. two's-complement signed overflow.
  - Reset value 0. Updates only on in_valid; holds otherwise.
- Undefined: the port and its logic do not exist. All other behaviour is identical.

Test Plan:
- WIDTH=1 exhaustive: reset, then apply the eight (a,b,c) triples 000..111 with in_valid=1, one per cycle. Required {carry,sum} one cycle later: 00,01,01,10,01,10,10,11.
- Hold check: WIDTH=1, drive a=1,b=1,c=0 with in_valid=1, then in_valid=0 with a=0,b=0,c=1. Required: sum=0, carry=1 persist; out_valid goes 1 then 0.
- Reset priority: rst=1 and in_valid=1 with a=1,b=1,c=1 in the same cycle. Required next cycle: sum=0, carry=0, out_valid=0.
- WIDTH=8 carry ripple: a=8'hFF, b=8'h00, c=1. Required: sum=8'h00, carry=1, out_valid=1 after 1 cycle.
- WIDTH=8 mixed: a=8'h5A, b=8'hA5, c=0 gives sum=8'hFF, carry=0. Then a=8'h80, b=8'h80, c=0 gives sum=8'h00, carry=1 (overflow=1 when FA_OVERFLOW_EN is defined).
- Random regression: WIDTH=16, 1000 random back-to-back vectors. Each {carry,sum} must equal a+b+c one cycle later.
